fir_hls_sdiv_23s_7ns_16_seq: RTL

FIR_HLS_SDIV_23S_7NS_16_SEQ -- requirements
Module: fir_hls_sdiv_23s_7ns_16_seq

---
 rtl/fir_hls_sdiv_23s_7ns_16_seq.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/fir_hls_sdiv_23s_7ns_16_seq.sv
// Sequential signed/unsigned divider: restoring division, one quotient bit per clock, with saturation and divide-by-zero flagging.
// Optional build macro FIR_HLS_SDIV_ROUND_NEAREST_EN selects round-to-nearest (ties away from zero) instead of truncation.
//
// state | meaning
// IDLE  | in_ready=1, waiting for an operand pair
// CALC  | one restoring-division step per cycle, din0_WIDTH cycles
// FIX   | apply signs, rounding, saturation and divide-by-zero override
// DONE  | out_valid=1, result held until out_ready
module fir_hls_sdiv_23s_7ns_16_seq #(
   parameter int din0_WIDTH = 23,
   parameter int din1_WIDTH = 7,
   parameter int dout_WIDTH = 16
) (
   input  logic                  ap_clk,
   input  logic                  ap_rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [din0_WIDTH-1:0] din0,
   input  logic [din1_WIDTH-1:0] din1,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [dout_WIDTH-1:0] dout,
   output logic [din1_WIDTH:0]   rem,
   output logic                  ovf,
   output logic                  dbz
);

   localparam int CW = $clog2(din0_WIDTH + 1);
   localparam int RW = din1_WIDTH + 1;
   localparam int QW = din0_WIDTH + 1;

   localparam logic [QW-1:0]         MAG_POS  = QW'((2 ** (dout_WIDTH - 1)) - 1);
   localparam logic [QW-1:0]         MAG_NEG  = QW'(2 ** (dout_WIDTH - 1));
   localparam logic [dout_WIDTH-1:0] DOUT_MAX = {1'b0, {(dout_WIDTH-1){1'b1}}};
   localparam logic [dout_WIDTH-1:0] DOUT_MIN = {1'b1, {(dout_WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

   state_t                  state_q, state_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic [din0_WIDTH-1:0]   num_q, num_d;
   logic [din1_WIDTH-1:0]   div_q, div_d;
   logic [RW-1:0]           part_q, part_d;
   logic                    neg_q, neg_d;
   logic [dout_WIDTH-1:0]   dout_q, dout_d;
   logic [RW-1:0]           rem_q, rem_d;
   logic                    ovf_q, ovf_d;
   logic                    dbz_q, dbz_d;

   logic [din0_WIDTH-1:0]   din0_mag;
   logic [RW-1:0]           trial;
   logic [RW-1:0]           diff;
   logic                    ge;
   logic                    rnd;
   logic [QW-1:0]           q_adj;
   logic [RW-1:0]           rem_pos;
   logic [RW-1:0]           rem_fix;
   logic                    sat_hi;
   logic                    sat_lo;

   // state register
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (in_valid)      state_d = S_CALC;
         S_CALC:  if (cnt_q == '0)   state_d = S_FIX;
         S_FIX:                      state_d = S_DONE;
         S_DONE:  if (out_ready)     state_d = S_IDLE;
         default:                    state_d = S_IDLE;
      endcase
   end

   // handshake outputs
   always_comb begin
      in_ready  = (state_q == S_IDLE);
      out_valid = (state_q == S_DONE);
   end

   // Unary minus of the most negative dividend yields 2^(din0_WIDTH-1), which fits unsigned.
   always_comb begin
      din0_mag = din0[din0_WIDTH-1] ? (-din0) : din0;
      trial    = {part_q[RW-2:0], num_q[din0_WIDTH-1]};
      diff     = trial - {1'b0, div_q};
      ge       = (trial >= {1'b0, div_q});
   end

   always_comb begin
`ifdef FIR_HLS_SDIV_ROUND_NEAREST_EN
      rnd = (div_q != '0) && ({part_q, 1'b0} >= {2'b00, div_q});
`else
      rnd = 1'b0;
`endif
      q_adj   = {1'b0, num_q} + QW'(rnd);
      rem_pos = rnd ? (part_q - {1'b0, div_q}) : part_q;
      rem_fix = neg_q ? (-rem_pos) : rem_pos;
      sat_hi  = !neg_q && (q_adj > MAG_POS);
      sat_lo  = neg_q && (q_adj > MAG_NEG);
   end

   // datapath next-state
   always_comb begin
      cnt_d  = cnt_q;
      num_d  = num_q;
      div_d  = div_q;
      part_d = part_q;
      neg_d  = neg_q;
      dout_d = dout_q;
      rem_d  = rem_q;
      ovf_d  = ovf_q;
      dbz_d  = dbz_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               num_d  = din0_mag;
               div_d  = din1;
               neg_d  = din0[din0_WIDTH-1];
               part_d = '0;
               cnt_d  = CW'(din0_WIDTH - 1);
            end
         end
         S_CALC: begin
            part_d = ge ? diff : trial;
            num_d  = {num_q[din0_WIDTH-2:0], ge};
            cnt_d  = cnt_q - CW'(1);
         end
         S_FIX: begin
            if (div_q == '0) begin
               dout_d = neg_q ? DOUT_MIN : DOUT_MAX;
               rem_d  = '0;
               ovf_d  = 1'b0;
               dbz_d  = 1'b1;
            end else begin
               rem_d = rem_fix;
               dbz_d = 1'b0;
               if (sat_hi) begin
                  dout_d = DOUT_MAX;
                  ovf_d  = 1'b1;
               end else if (sat_lo) begin
                  dout_d = DOUT_MIN;
                  ovf_d  = 1'b1;
               end else begin
                  dout_d = neg_q ? (-q_adj[dout_WIDTH-1:0]) : q_adj[dout_WIDTH-1:0];
                  ovf_d  = 1'b0;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         cnt_q  <= '0;
         num_q  <= '0;
         div_q  <= '0;
         part_q <= '0;
         neg_q  <= 1'b0;
         dout_q <= '0;
         rem_q  <= '0;
         ovf_q  <= 1'b0;
         dbz_q  <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         num_q  <= num_d;
         div_q  <= div_d;
         part_q <= part_d;
         neg_q  <= neg_d;
         dout_q <= dout_d;
         rem_q  <= rem_d;
         ovf_q  <= ovf_d;
         dbz_q  <= dbz_d;
      end
   end

   always_comb begin
      dout = dout_q;
      rem  = rem_q;
      ovf  = ovf_q;
      dbz  = dbz_q;
   end

endmodule
